iob_nativebridge_slice: RTL and testbench

IOB_NATIVEBRIDGE_SLICE -- requirements
Module: iob_nativebridge_slice

---
 rtl/iob_nativebridge_slice_pkg.sv | 23 ++
 rtl/iob_nativebridge_skid.sv | 122 ++++++++++++
 rtl/iob_nativebridge_slice.sv | 131 +++++++++++++
 tb/tb_iob_nativebridge_slice.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_nativebridge_slice_pkg.sv
// iob_nativebridge_slice_pkg
// Shared definitions for the native-bridge request slice.
//   skid_state_t  : occupancy of the two-entry request skid buffer
//   PEND_W        : width of the outstanding-read counter (pending_o)
//   pend_at_limit : true when the outstanding-read count has reached a limit
package iob_nativebridge_slice_pkg;

  // EMPTY: nothing buffered; ONE: main entry valid; FULL: main + skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Counter width is fixed so that MAX_PENDING can range up to 15
  localparam int PEND_W = 4;

  function automatic logic pend_at_limit(input logic [PEND_W-1:0] pend,
                                         input int                limit);
    return pend == PEND_W'(limit);
  endfunction

endpackage

// File: rtl/iob_nativebridge_skid.sv
// iob_nativebridge_skid
// Two-entry (main + skid) request buffer between an upstream IOb requester
// and the downstream native bridge. The upstream ready is a register so the
// requester never sees a combinational path from the downstream side.
// Ports:
//   clk, cke, rst          : clock, clock enable, async active-high reset
//   in_valid/addr/wdata/wstrb, in_ready  : upstream request side
//   out_valid/addr/wdata/wstrb           : main entry presented downstream
//   out_pop                : main entry consumed this cycle (handshake)
module iob_nativebridge_skid
  import iob_nativebridge_slice_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                cke,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W/8-1:0] in_wstrb,
  output logic                in_ready,
  output logic                out_valid,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  input  logic                out_pop
);

  skid_state_t state_q;
  skid_state_t state_d;

  logic [ADDR_W-1:0]   skid_addr;
  logic [DATA_W-1:0]   skid_wdata;
  logic [DATA_W/8-1:0] skid_wstrb;

  logic accept;
  logic pop;
  logic load_main_new;
  logic load_main_skid;
  logic load_skid;

  assign accept    = in_valid & in_ready & cke;
  assign pop       = out_pop & cke & (state_q != EMPTY);
  assign out_valid = (state_q != EMPTY);

  // Next-state decode. A simultaneous accept and pop in ONE refills main
  // directly, which is what lets the slice stream one request per cycle.
  // In FULL the upstream ready is low, so only a pop can happen there.
  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main_new = 1'b1;
          state_d       = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_new = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Ready is registered from the next state so it is already low in the
  // first cycle the buffer is FULL, and stays low for the whole reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      in_ready <= 1'b0;
    end else if (cke) begin
      state_q  <= state_d;
      in_ready <= (state_d != FULL);
    end
  end

  // Payload registers; the load strobes already include the clock enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr   <= '0;
      out_wdata  <= '0;
      out_wstrb  <= '0;
      skid_addr  <= '0;
      skid_wdata <= '0;
      skid_wstrb <= '0;
    end else begin
      if (load_main_new) begin
        out_addr  <= in_addr;
        out_wdata <= in_wdata;
        out_wstrb <= in_wstrb;
      end else if (load_main_skid) begin
        out_addr  <= skid_addr;
        out_wdata <= skid_wdata;
        out_wstrb <= skid_wstrb;
      end
      if (load_skid) begin
        skid_addr  <= in_addr;
        skid_wdata <= in_wdata;
        skid_wstrb <= in_wstrb;
      end
    end
  end

endmodule

// File: rtl/iob_nativebridge_slice.sv
// iob_nativebridge_slice
// Register slice in front of a native bridge: buffers IOb requests in a
// two-entry skid buffer, limits outstanding reads to MAX_PENDING and returns
// read responses upstream. Stray responses (none outstanding) are dropped
// and flagged on err_o.
// Build option: define IOB_NATIVEBRIDGE_SLICE_RSP_REG_EN to register the
// response path (one cycle latency, rdata holds between responses);
// otherwise responses pass straight through.
// Ports:
//   clk_i, cke_i, arst_i             : clock, clock enable, async reset
//   iob_valid_i .. iob_rdata_o       : upstream IOb slave side
//   iob_valid_o .. iob_rdata_i       : downstream side toward the bridge
//   pending_o                        : outstanding read count
//   err_o                            : one-cycle pulse on a stray response
module iob_nativebridge_slice
  import iob_nativebridge_slice_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic [3:0]          pending_o,
  output logic                err_o
);

  logic              main_valid;
  logic              main_is_read;
  logic              read_blocked;
  logic              issue_read;
  logic              rsp_hit;
  logic              rsp_stray;
  logic [PEND_W-1:0] pending_q;
  logic              err_q;

  iob_nativebridge_skid #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk_i),
    .cke      (cke_i),
    .rst      (arst_i),
    .in_valid (iob_valid_i),
    .in_addr  (iob_addr_i),
    .in_wdata (iob_wdata_i),
    .in_wstrb (iob_wstrb_i),
    .in_ready (iob_ready_o),
    .out_valid(main_valid),
    .out_addr (iob_addr_o),
    .out_wdata(iob_wdata_o),
    .out_wstrb(iob_wstrb_o),
    .out_pop  (iob_valid_o & iob_ready_i)
  );

  // A read at the head is held back while the outstanding window is full;
  // writes never wait on it because they produce no response.
  assign main_is_read = (iob_wstrb_o == '0);
  assign read_blocked = main_is_read & pend_at_limit(pending_q, MAX_PENDING);
  assign iob_valid_o  = main_valid & ~read_blocked;

  assign issue_read = iob_valid_o & iob_ready_i & cke_i & main_is_read;
  assign rsp_hit    = iob_rvalid_i & cke_i & (pending_q != '0);
  assign rsp_stray  = iob_rvalid_i & cke_i & (pending_q == '0);

  // Outstanding-read counter; an issue and a response in the same cycle
  // cancel out. It cannot pass MAX_PENDING because issue is gated above.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pending_q <= '0;
    end else if (issue_read && !rsp_hit) begin
      pending_q <= pending_q + 1'b1;
    end else if (rsp_hit && !issue_read) begin
      pending_q <= pending_q - 1'b1;
    end
  end

  // Error flag is registered so it is a clean single-cycle pulse that is
  // guaranteed low during reset regardless of the response inputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_q <= 1'b0;
    end else if (cke_i) begin
      err_q <= rsp_stray;
    end
  end

  assign pending_o = pending_q;
  assign err_o     = err_q;

`ifdef IOB_NATIVEBRIDGE_SLICE_RSP_REG_EN
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  // Registered response: rdata keeps the last delivered word between hits.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (cke_i) begin
      rvalid_q <= rsp_hit;
      if (rsp_hit) begin
        rdata_q <= iob_rdata_i;
      end
    end
  end

  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = rdata_q;
`else
  // Pass-through response; data is forced to zero while reset is held.
  assign iob_rvalid_o = rsp_hit & ~arst_i;
  assign iob_rdata_o  = arst_i ? '0 : iob_rdata_i;
`endif

endmodule

// File: tb/tb_iob_nativebridge_slice.sv
// tb_iob_nativebridge_slice
// Self-checking bench for iob_nativebridge_slice. Requests are pushed to a
// scoreboard when accepted upstream and compared when they leave downstream;
// accepted responses are pushed with their due cycle and compared when
// iob_rvalid_o appears. Build with IOB_NATIVEBRIDGE_SLICE_RSP_REG_EN to
// expect one cycle of response latency.
module tb_iob_nativebridge_slice;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXP = 4;
`ifdef IOB_NATIVEBRIDGE_SLICE_RSP_REG_EN
  localparam int RSP_LAT = 1;
`else
  localparam int RSP_LAT = 0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_rdata;
  } vec_t;

  logic          clk;
  logic          cke;
  logic          arst;
  logic          up_valid;
  logic [AW-1:0] up_addr;
  logic [DW-1:0] up_wdata;
  logic [3:0]    up_wstrb;
  logic          up_ready;
  logic          up_rvalid;
  logic [DW-1:0] up_rdata;
  logic          dn_valid;
  logic [AW-1:0] dn_addr;
  logic [DW-1:0] dn_wdata;
  logic [3:0]    dn_wstrb;
  logic          dn_ready;
  logic          dn_rvalid;
  logic [DW-1:0] dn_rdata;
  logic [3:0]    pending;
  logic          err;

  iob_nativebridge_slice #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk_i       (clk),
    .cke_i       (cke),
    .arst_i      (arst),
    .iob_valid_i (up_valid),
    .iob_addr_i  (up_addr),
    .iob_wdata_i (up_wdata),
    .iob_wstrb_i (up_wstrb),
    .iob_ready_o (up_ready),
    .iob_rvalid_o(up_rvalid),
    .iob_rdata_o (up_rdata),
    .iob_valid_o (dn_valid),
    .iob_addr_o  (dn_addr),
    .iob_wdata_o (dn_wdata),
    .iob_wstrb_o (dn_wstrb),
    .iob_ready_i (dn_ready),
    .iob_rvalid_i(dn_rvalid),
    .iob_rdata_i (dn_rdata),
    .pending_o   (pending),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int          total;
  int          bad;
  int          cyc;
  int          model_pend;
  logic        err_exp;
  logic        rsp_next;
  logic [31:0] rsp_data;
  logic        up_acc_flag;
  logic        auto_rsp;
  int          dn_count;
  int          max_pend;
  int          last_rvi_cyc;
  int          last_rvo_cyc;
  logic [31:0] last_rdata;
  req_t        src[$];
  req_t        req_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] got_rdata[$];
  int          dn_cyc[$];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h want=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%b want=%b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  // Sampled on the falling edge: everything seen here is what the next
  // rising edge will act on.
  task automatic check_output();
    req_t e;
    rsp_t r;
    logic up_acc;
    logic dn_acc;
    logic hit;
    logic stray;
    logic inc;
    up_acc_flag = 1'b0;
    if (arst) begin
      req_q.delete();
      rsp_q.delete();
      model_pend = 0;
      err_exp    = 1'b0;
      rsp_next   = 1'b0;
      last_rdata = 32'h0;
      return;
    end
    check("pending", 32'(pending), 32'(model_pend));
    check_bit("err", err, err_exp);
    if (32'(pending) > 32'(max_pend)) max_pend = int'(pending);

    up_acc = up_valid & up_ready & cke;
    if (up_acc) begin
      req_q.push_back('{up_addr, up_wdata, up_wstrb});
      up_acc_flag = 1'b1;
    end

    dn_acc = dn_valid & dn_ready & cke;
    inc    = 1'b0;
    if (dn_acc) begin
      if (req_q.size() == 0) begin
        fail_now("dn_unexpected_req");
      end else begin
        e = req_q.pop_front();
        check("dn_addr", dn_addr, e.addr);
        check("dn_wdata", dn_wdata, e.wdata);
        check("dn_wstrb", 32'(dn_wstrb), 32'(e.wstrb));
      end
      dn_count++;
      dn_cyc.push_back(cyc);
      if (dn_wstrb == 4'h0) begin
        inc = 1'b1;
        if (auto_rsp) begin
          rsp_next = 1'b1;
          rsp_data = {dn_addr[15:0], 16'hC0DE};
        end
      end
    end

    hit   = dn_rvalid & cke & (model_pend != 0);
    stray = dn_rvalid & cke & (model_pend == 0);
    if (dn_rvalid) last_rvi_cyc = cyc;
    if (hit) rsp_q.push_back('{dn_rdata, cyc + RSP_LAT});

    if (up_rvalid) begin
      got_rdata.push_back(up_rdata);
      last_rvo_cyc = cyc;
      if (rsp_q.size() == 0) begin
        fail_now("rvalid_unexpected");
      end else begin
        r = rsp_q.pop_front();
        check("rsp_rdata", up_rdata, r.data);
        check("rsp_latency", cyc, r.due);
        last_rdata = r.data;
      end
    end else begin
      if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
        fail_now("rvalid_missing");
        void'(rsp_q.pop_front());
      end
`ifdef IOB_NATIVEBRIDGE_SLICE_RSP_REG_EN
      check("rdata_hold", up_rdata, last_rdata);
`endif
    end

    if (inc && !hit) model_pend++;
    else if (hit && !inc) model_pend--;
    err_exp = stray;
  endtask

  // One clock: sample at the falling edge, then drive just after the rise.
  task automatic tick();
    req_t dummy;
    @(negedge clk);
    check_output();
    @(posedge clk);
    cyc++;
    #1;
    if (up_acc_flag && src.size() > 0) dummy = src.pop_front();
    if (src.size() > 0) begin
      up_valid = 1'b1;
      up_addr  = src[0].addr;
      up_wdata = src[0].wdata;
      up_wstrb = src[0].wstrb;
    end else begin
      up_valid = 1'b0;
    end
    dn_rvalid = rsp_next;
    dn_rdata  = rsp_next ? rsp_data : 32'h0;
    rsp_next  = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    src.push_back('{a, d, s});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_ready"}, up_ready, 1'b0);
    check_bit({tag, "_dn_valid"}, dn_valid, 1'b0);
    check({tag, "_pending"}, 32'(pending), 32'h0);
    check_bit({tag, "_err"}, err, 1'b0);
    check_bit({tag, "_rvalid"}, up_rvalid, 1'b0);
    check({tag, "_rdata"}, up_rdata, 32'h0);
    check({tag, "_dn_addr"}, dn_addr, 32'h0);
    check({tag, "_dn_wdata"}, dn_wdata, 32'h0);
    check({tag, "_dn_wstrb"}, 32'(dn_wstrb), 32'h0);
  endtask

  initial begin
    int base;
    int dbase;
    int d0;

    vecs[0] = '{32'h0000_0100, 32'h0100_C0DE};
    vecs[1] = '{32'h0000_0104, 32'h0104_C0DE};
    vecs[2] = '{32'h0000_0108, 32'h0108_C0DE};
    vecs[3] = '{32'h0000_010C, 32'h010C_C0DE};
    vecs[4] = '{32'h0000_0110, 32'h0110_C0DE};
    vecs[5] = '{32'h0000_0114, 32'h0114_C0DE};
    vecs[6] = '{32'h0000_0118, 32'h0118_C0DE};
    vecs[7] = '{32'h0000_011C, 32'h011C_C0DE};

    total = 0; bad = 0; cyc = 0; model_pend = 0; err_exp = 1'b0;
    rsp_next = 1'b0; rsp_data = 32'h0; up_acc_flag = 1'b0; auto_rsp = 1'b0;
    dn_count = 0; max_pend = 0; last_rvi_cyc = 0; last_rvo_cyc = 0; last_rdata = 32'h0;
    arst = 1'b1; cke = 1'b1;
    up_valid = 1'b0; up_addr = '0; up_wdata = '0; up_wstrb = '0;
    dn_ready = 1'b0; dn_rvalid = 1'b0; dn_rdata = '0;

    // Reset state and release
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    tick();
    arst = 1'b0;
    check_bit("ready_at_release", up_ready, 1'b0);
    tick();
    check_bit("ready_after_release", up_ready, 1'b1);

    // Single write passes with one cycle of latency and no response
    dn_ready = 1'b1;
    apply_stimulus(32'h10, 32'hDEAD_BEEF, 4'hF);
    tick();
    check_bit("wr_dn_idle", dn_valid, 1'b0);
    tick();
    check_bit("wr_dn_valid", dn_valid, 1'b1);
    check("wr_dn_addr", dn_addr, 32'h10);
    check("wr_dn_wdata", dn_wdata, 32'hDEAD_BEEF);
    check("wr_dn_wstrb", 32'(dn_wstrb), 32'hF);
    repeat (3) tick();
    check_bit("wr_no_rvalid", up_rvalid, 1'b0);
    check_bit("wr_dn_done", dn_valid, 1'b0);

    // Table: eight back-to-back reads with one-cycle responder
    auto_rsp = 1'b1;
    base     = got_rdata.size();
    dbase    = dn_cyc.size();
    max_pend = 0;
    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i].addr, 32'h0, 4'h0);
    for (int i = 0; i < 60 && got_rdata.size() < base + 8; i++) tick();
    check("rd_count", got_rdata.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < got_rdata.size()) check("rd_data_order", got_rdata[base + i], vecs[i].exp_rdata);
      else fail_now("rd_data_missing");
    end
    for (int i = 1; i < 8; i++) begin
      if (dbase + i < dn_cyc.size()) check("rd_issue_gap", dn_cyc[dbase + i] - dn_cyc[dbase + i - 1], 1);
      else fail_now("rd_issue_missing");
    end
    check_bit("rd_pend_le_1", max_pend <= 1, 1'b1);
    auto_rsp = 1'b0;
    repeat (2) tick();

    // Backpressure: two accepted, third held, then drained in order
    dn_ready = 1'b0;
    d0 = dn_count;
    apply_stimulus(32'h40, 32'h1111_1111, 4'hF);
    apply_stimulus(32'h44, 32'h2222_2222, 4'h3);
    apply_stimulus(32'h48, 32'h3333_3333, 4'hC);
    tick();
    check_bit("bp_ready_0", up_ready, 1'b1);
    tick();
    check_bit("bp_ready_1", up_ready, 1'b1);
    tick();
    check_bit("bp_ready_low", up_ready, 1'b0);
    repeat (3) tick();
    check("bp_third_held", src.size(), 1);
    check_bit("bp_ready_still_low", up_ready, 1'b0);
    check_bit("bp_dn_valid", dn_valid, 1'b1);
    check("bp_dn_addr_stable", dn_addr, 32'h40);
    check("bp_dn_wdata_stable", dn_wdata, 32'h1111_1111);
    dn_ready = 1'b1;
    for (int i = 0; i < 20 && dn_count - d0 < 3; i++) tick();
    tick();
    check("bp_delivered", dn_count - d0, 3);
    check("bp_sb_empty", req_q.size(), 0);

    // Outstanding limit: fifth read stalls until a response returns
    d0 = dn_count;
    for (int i = 0; i < 5; i++) apply_stimulus(32'h200 + 32'(4 * i), 32'h0, 4'h0);
    for (int i = 0; i < 20 && dn_count - d0 < 4; i++) tick();
    repeat (3) tick();
    check("ps_pending_full", 32'(pending), 32'd4);
    check("ps_issued", dn_count - d0, 4);
    check_bit("ps_stalled", dn_valid, 1'b0);
    check("ps_head_addr", dn_addr, 32'h210);
    dn_rvalid = 1'b1;
    dn_rdata  = 32'hA0A0_0001;
    tick();
    check_bit("ps_released", dn_valid, 1'b1);
    tick();
    check("ps_fifth_issued", dn_count - d0, 5);
    check("ps_pending_after", 32'(pending), 32'd4);
    for (int k = 0; k < 4; k++) begin
      dn_rvalid = 1'b1;
      dn_rdata  = 32'hA0A0_0010 + 32'(k);
      tick();
    end
    repeat (2) tick();
    check("ps_drained", 32'(pending), 32'd0);

    // Stray response with nothing outstanding
    dn_rvalid = 1'b1;
    dn_rdata  = 32'h0BAD_F00D;
    #1;
    check_bit("stray_no_rvalid_now", up_rvalid, 1'b0);
    tick();
    check_bit("stray_err_pulse", err, 1'b1);
    check_bit("stray_no_rvalid", up_rvalid, 1'b0);
    check("stray_pending", 32'(pending), 32'd0);
    tick();
    check_bit("stray_err_clear", err, 1'b0);

    // Reset with FULL buffer and three reads outstanding
    d0 = dn_count;
    for (int i = 0; i < 3; i++) apply_stimulus(32'h300 + 32'(4 * i), 32'h0, 4'h0);
    for (int i = 0; i < 20 && dn_count - d0 < 3; i++) tick();
    tick();
    check("rst_pending_3", 32'(pending), 32'd3);
    dn_ready = 1'b0;
    apply_stimulus(32'h400, 32'h4444_4444, 4'hF);
    apply_stimulus(32'h404, 32'h5555_5555, 4'hF);
    for (int i = 0; i < 10 && !(up_ready == 1'b0 && src.size() == 0); i++) tick();
    check_bit("rst_buffer_full", up_ready, 1'b0);
    arst = 1'b1;
    src.delete();
    up_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    arst = 1'b0;
    check_bit("midrst_ready_hold", up_ready, 1'b0);
    tick();
    check_bit("midrst_ready_up", up_ready, 1'b1);
    check("midrst_pending", 32'(pending), 32'd0);
    dn_rvalid = 1'b1;
    dn_rdata  = 32'h55AA_55AA;
    tick();
    check_bit("late_rsp_err", err, 1'b1);
    tick();

    // Clean read after reset, latency depends on build
    auto_rsp = 1'b1;
    dn_ready = 1'b1;
    base = got_rdata.size();
    apply_stimulus(32'h20, 32'h0, 4'h0);
    for (int i = 0; i < 20 && got_rdata.size() <= base; i++) tick();
    if (got_rdata.size() > base) check("clean_rdata", got_rdata[base], 32'h0020_C0DE);
    else fail_now("clean_rdata_missing");
    check("clean_latency", last_rvo_cyc - last_rvi_cyc, RSP_LAT);
    auto_rsp = 1'b0;
    repeat (3) tick();
    check("final_pending", 32'(pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
